// File: rtl/tlc_pkg.sv
// Shared types and constants for the two-road traffic light controller.
package tlc_pkg;

    typedef enum logic [1:0] {
        MG = 2'd0,
        MY = 2'd1,
        CG = 2'd2,
        CY = 2'd3
    } phase_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low segments {dp,g,f,e,d,c,b,a}, dp off; non-decimal values blank.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/traffic_top_ctrl_seg_scan.sv
// Four-digit multiplexed 7-segment driver showing cnt as two identical BCD pairs.
module seg_scan
    import tlc_pkg::*;
#(
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] cnt,
    input  logic       blank,
    output logic [3:0] sm_wei,
    output logic [7:0] sm_duan
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SW-1:0] scan_q;
    logic [1:0]    idx_q;
    logic [3:0]    tens;
    logic [3:0]    units;
    logic [3:0]    digit;

    always_comb begin
        tens  = 4'(cnt / 7'd10);
        units = 4'(cnt % 7'd10);
        // Odd positions (3 and 1) carry the tens of each pair.
        digit = idx_q[0] ? tens : units;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q  <= '0;
            idx_q   <= 2'd0;
            sm_wei  <= 4'b1110;
            sm_duan <= SEG_BLANK;
        end else begin
            if (scan_q == SW'(SCAN_DIV - 1)) begin
                scan_q <= '0;
                idx_q  <= idx_q + 2'd1;
            end else begin
                scan_q <= scan_q + SW'(1);
            end
            sm_wei  <= ~(4'b0001 << idx_q);
            sm_duan <= blank ? SEG_BLANK : seg7(digit);
        end
    end

endmodule

// File: rtl/traffic_top_ctrl.sv
// Two-road intersection controller: phase sequencing, pedestrian shortening,
// peak timing, standby blink, all-red override and countdown display.
module traffic_top_ctrl
    import tlc_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int SCAN_DIV  = 50_000,
    parameter int T_MG      = 30,
    parameter int T_MG_PEAK = 45,
    parameter int T_CG      = 20,
    parameter int T_CG_PEAK = 30,
    parameter int T_Y       = 3,
    parameter int T_PED     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Cm,
    input  logic       Cc,
    input  logic       PQm,
    input  logic       PQc,
    input  logic       peak,
    input  logic       set,
    input  logic       online,
    output logic       online_led,
    output logic       set_led,
    output logic [2:0] m_led,
    output logic [2:0] c_led,
    output logic [3:0] sm_wei,
    output logic [7:0] sm_duan
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [6:0] LD_MG      = 7'(T_MG);
    localparam logic [6:0] LD_MG_PEAK = 7'(T_MG_PEAK);
    localparam logic [6:0] LD_CG      = 7'(T_CG);
    localparam logic [6:0] LD_CG_PEAK = 7'(T_CG_PEAK);
    localparam logic [6:0] LD_Y       = 7'(T_Y);
    localparam logic [6:0] LD_PED     = 7'(T_PED);

    logic [TW-1:0] div_q;
    logic          tick;
    phase_t        state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic          blink_q, blink_d;
    logic          ped_short;
    logic [6:0]    main_green;
    logic [6:0]    country_green;

    assign online_led = online;
    assign set_led    = set;
    assign tick       = (div_q == TW'(TICK_DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            state_q <= MG;
            cnt_q   <= LD_MG;
            blink_q <= 1'b0;
        end else begin
            div_q   <= tick ? '0 : div_q + TW'(1);
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        main_green    = peak ? LD_MG_PEAK : LD_MG;
        country_green = peak ? LD_CG_PEAK : LD_CG;
        ped_short     = ((PQm && state_q == MG) || (PQc && state_q == CG))
                        && (cnt_q > LD_PED);
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blink_d = 1'b0;
        m_led   = GRN;
        c_led   = RED;

        if (!set) begin
            state_d = MG;
            cnt_d   = LD_MG;
            blink_d = blink_q ^ tick;
            m_led   = {1'b0, blink_q, 1'b0};
            c_led   = {1'b0, blink_q, 1'b0};
        end else if (online) begin
            m_led = RED;
            c_led = RED;
        end else begin
            case (state_q)
                MG:      begin m_led = GRN; c_led = RED; end
                MY:      begin m_led = YEL; c_led = RED; end
                CG:      begin m_led = RED; c_led = GRN; end
                default: begin m_led = RED; c_led = YEL; end
            endcase

            // A pedestrian load takes precedence over a coincident tick.
            if (ped_short) begin
                cnt_d = LD_PED;
            end else if (tick) begin
                if (cnt_q > 7'd1) begin
                    cnt_d = cnt_q - 7'd1;
                end else begin
                    case (state_q)
                        MG: begin
                            if (Cm && !Cc) begin
                                cnt_d = main_green;
                            end else begin
                                state_d = MY;
                                cnt_d   = LD_Y;
                            end
                        end
                        MY: begin
                            state_d = CG;
                            cnt_d   = country_green;
                        end
                        CG: begin
                            if (Cc && !Cm) begin
                                cnt_d = country_green;
                            end else begin
                                state_d = CY;
                                cnt_d   = LD_Y;
                            end
                        end
                        default: begin
                            state_d = MG;
                            cnt_d   = main_green;
                        end
                    endcase
                end
            end
        end
    end

    seg_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_seg_scan (
        .clk    (clk),
        .rst    (rst),
        .cnt    (cnt_q),
        .blank  (!set || online),
        .sm_wei (sm_wei),
        .sm_duan(sm_duan)
    );

endmodule

// File: tb/tb_traffic_top_ctrl.sv
// Self-checking bench: directed scenarios then random input runs against a
// phase-table reference model of the intersection.
module tb_traffic_top_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int SCAN_DIV  = 2;
    localparam int T_MG      = 6;
    localparam int T_MG_PEAK = 9;
    localparam int T_CG      = 4;
    localparam int T_CG_PEAK = 7;
    localparam int T_Y       = 2;
    localparam int T_PED     = 2;

    logic       clk = 1'b0;
    logic       rst, Cm, Cc, PQm, PQc, peak, set, online;
    logic       online_led, set_led;
    logic [2:0] m_led, c_led;
    logic [3:0] sm_wei;
    logic [7:0] sm_duan;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0..3 = main green, main yellow, country green, country yellow.
    int         mp;
    int         mrem;
    bit         mblink;
    int         medge;
    logic [3:0] exp_wei;
    logic [7:0] exp_duan;

    traffic_top_ctrl #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .T_MG     (T_MG),
        .T_MG_PEAK(T_MG_PEAK),
        .T_CG     (T_CG),
        .T_CG_PEAK(T_CG_PEAK),
        .T_Y      (T_Y),
        .T_PED    (T_PED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Cm        (Cm),
        .Cc        (Cc),
        .PQm       (PQm),
        .PQc       (PQc),
        .peak      (peak),
        .set       (set),
        .online    (online),
        .online_led(online_led),
        .set_led   (set_led),
        .m_led     (m_led),
        .c_led     (c_led),
        .sm_wei    (sm_wei),
        .sm_duan   (sm_duan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic int phase_time(input int ph, input bit pk);
        case (ph)
            0:       return pk ? T_MG_PEAK : T_MG;
            2:       return pk ? T_CG_PEAK : T_CG;
            default: return T_Y;
        endcase
    endfunction

    function automatic logic [2:0] main_light(input int ph);
        case (ph)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] country_light(input int ph);
        case (ph)
            2:       return 3'b001;
            3:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [7:0] seg_exp(input int d);
        case (d)
            0:       return 8'hC0;
            1:       return 8'hF9;
            2:       return 8'hA4;
            3:       return 8'hB0;
            4:       return 8'h99;
            5:       return 8'h92;
            6:       return 8'h82;
            7:       return 8'hF8;
            8:       return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    task automatic model_reset();
        mp       = 0;
        mrem     = T_MG;
        mblink   = 1'b0;
        medge    = 0;
        exp_wei  = 4'b1110;
        exp_duan = 8'hFF;
    endtask

    // One clock edge of the intersection as described by its rules.
    task automatic model_step();
        bit tick;
        int idx;
        int digit;
        medge++;
        tick     = (medge % TICK_DIV) == 0;
        idx      = ((medge - 1) / SCAN_DIV) % 4;
        digit    = (idx % 2 == 1) ? mrem / 10 : mrem % 10;
        exp_wei  = ~(4'b0001 << idx);
        exp_duan = (!set || online) ? 8'hFF : seg_exp(digit);

        if (!set) begin
            mp   = 0;
            mrem = T_MG;
            if (tick) mblink = !mblink;
        end else begin
            mblink = 1'b0;
            if (!online) begin
                if (((PQm && mp == 0) || (PQc && mp == 2)) && mrem > T_PED) begin
                    mrem = T_PED;
                end else if (tick) begin
                    if (mrem > 1) begin
                        mrem--;
                    end else if (mp == 0 && Cm && !Cc) begin
                        mrem = phase_time(0, peak);
                    end else if (mp == 2 && Cc && !Cm) begin
                        mrem = phase_time(2, peak);
                    end else begin
                        mp   = (mp + 1) % 4;
                        mrem = phase_time(mp, peak);
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [2:0] em, ec;
        if (!set) begin
            em = {1'b0, mblink, 1'b0};
            ec = em;
        end else if (online) begin
            em = 3'b100;
            ec = 3'b100;
        end else begin
            em = main_light(mp);
            ec = country_light(mp);
        end
        check("m_led", m_led, em);
        check("c_led", c_led, ec);
        check("sm_wei", sm_wei, exp_wei);
        check("sm_duan", sm_duan, exp_duan);
        check("online_led", online_led, online);
        check("set_led", set_led, set);
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            if (rst) model_reset();
            else     model_step();
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        run(3);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; Cm = 1'b0; Cc = 1'b0; PQm = 1'b0; PQc = 1'b0;
        peak = 1'b0; set = 1'b1; online = 1'b0;
        @(negedge clk);
        apply_reset();

        // Free-running cycle with no cars.
        run(64);

        // Main road held by a waiting main car, then country road held.
        Cm = 1'b1;
        run(60);
        Cm = 1'b0; Cc = 1'b1;
        run(70);
        Cc = 1'b0;
        run(30);

        // Peak timing at reloads, dropped mid-phase.
        peak = 1'b1;
        run(80);
        peak = 1'b0;
        run(40);

        // Pedestrian shortening on both roads.
        apply_reset();
        run(5);
        PQm = 1'b1;
        run(40);
        PQm = 1'b0; PQc = 1'b1;
        run(60);
        PQc = 1'b0;

        // All-red override mid-phase, then standby blink and recovery.
        run(37);
        online = 1'b1;
        run(25);
        online = 1'b0;
        run(25);
        set = 1'b0;
        run(30);
        online = 1'b1;
        run(10);
        online = 1'b0; set = 1'b1;
        run(40);

        // Random input segments with occasional asynchronous resets.
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 49) == 0) begin
                apply_reset();
            end
            Cm     = 1'($urandom_range(0, 1));
            Cc     = 1'($urandom_range(0, 1));
            PQm    = ($urandom_range(0, 7) == 0);
            PQc    = ($urandom_range(0, 7) == 0);
            peak   = 1'($urandom_range(0, 1));
            set    = ($urandom_range(0, 11) != 0);
            online = ($urandom_range(0, 9) == 0);
            run($urandom_range(1, 20));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
